nco_sweep_ctrl: RTL and testbench

Sequencer for the NCO core. It drives the NCO phase-increment input and its clock enable to produce linear frequency sweeps (chirps) or stepped hops. Each sweep is defined by start, stop, step and dwell values. The block sits between the register/config bus and the NCO. It also re-aligns the NCO output-valid with its own sweep window, so downstream mixers see only samples that belong to the current sweep.

---
 rtl/nco_sweep_ctrl_pkg.sv | 34 +++
 rtl/nco_sweep_ctrl_if.sv | 33 +++
 rtl/nco_sweep_ctrl_lat_pipe.sv | 42 ++++
 rtl/nco_sweep_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nco_sweep_ctrl_pkg.sv
// nco_sweep_pkg: shared types and defaults for the NCO sweep controller.
//   - sweep_state_e : controller states (IDLE / RUN / DRAIN)
//   - sweep_dir_e   : step direction derived from the sign of the step
//   - APR_DEF, DWELL_W_DEF, NCO_LAT_DEF : default parameter values
//   - step_dir()    : direction helper for a two's-complement step
package nco_sweep_pkg;

  localparam int unsigned APR_DEF     = 32;
  localparam int unsigned DWELL_W_DEF = 16;
  localparam int unsigned NCO_LAT_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sweep_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } sweep_dir_e;

  // The step is two's complement of the given width: its MSB selects down.
  function automatic sweep_dir_e step_dir(input logic [63:0] step_ext, input int unsigned width);
    sweep_dir_e dir;
    if (step_ext[6'(width - 1)]) begin
      dir = DIR_DOWN;
    end else begin
      dir = DIR_UP;
    end
    return dir;
  endfunction

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// nco_sweep_ctrl_if: configuration / control bus between the register block
// and the sweep controller.
//   master : drives cfg_start/stop/step/dwell/repeat, go, abort;
//            observes busy, done, err, sweep_wrap
//   slave  : the sweep controller side (reverse directions)
interface nco_sweep_ctrl_if import nco_sweep_pkg::*; #(
  parameter int unsigned APR     = APR_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF
) ();

  logic [APR-1:0]     cfg_start;
  logic [APR-1:0]     cfg_stop;
  logic [APR-1:0]     cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_repeat;
  logic               go;
  logic               abort;
  logic               busy;
  logic               done;
  logic               err;
  logic               sweep_wrap;

  modport master (
    output cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_repeat, go, abort,
    input  busy, done, err, sweep_wrap
  );

  modport slave (
    input  cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_repeat, go, abort,
    output busy, done, err, sweep_wrap
  );

endinterface

// File: rtl/nco_sweep_ctrl_lat_pipe.sv
// nco_lat_pipe: clock-enable gated shift register, DEPTH stages of WIDTH bits,
// with a synchronous clear. Used to delay sweep side-band information by the
// NCO pipeline latency so it lines up with the NCO output samples.
//   clk, reset_n : clock, synchronous active-low reset
//   clken_i      : advance the pipe (mirrors the NCO clock enable)
//   clr_i        : synchronous clear of every stage
//   d_i / q_o    : pipe input / output of the last stage
module nco_lat_pipe #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clken_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  // Stage registers: clear has priority over shifting.
  always_ff @(posedge clk) begin
    if (!reset_n || clr_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (clken_i) begin
      pipe_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i];
      end
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: sequencer driving an NCO phase increment and clock enable to
// produce linear chirps / stepped hops from start, stop, step and dwell.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : cfg_* / go / abort in; busy / done / err / sweep_wrap out
//   nco_valid_i  : NCO output valid
//   phi_inc_o    : phase increment to the NCO
//   nco_clken    : NCO clock enable (high in RUN and DRAIN)
//   seg_valid_o  : NCO output sample belongs to the active sweep
//   step_idx     : (only with NCO_SWEEP_STEP_IDX_EN) step index aligned with
//                  seg_valid_o
// Optional feature macro: NCO_SWEEP_STEP_IDX_EN.
module nco_sweep_ctrl import nco_sweep_pkg::*; #(
  parameter int unsigned APR     = APR_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF,
  parameter int unsigned NCO_LAT = NCO_LAT_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  nco_sweep_ctrl_if.slave bus,
  input  logic           nco_valid_i,
  output logic [APR-1:0] phi_inc_o,
  output logic           nco_clken,
  output logic           seg_valid_o
`ifdef NCO_SWEEP_STEP_IDX_EN
  ,
  output logic [15:0]    step_idx
`endif
);

  localparam int unsigned DRAIN_W = (NCO_LAT > 1) ? $clog2(NCO_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(NCO_LAT - 1);

  sweep_state_e       state_q, state_d;
  logic [APR-1:0]     phi_q, phi_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [APR-1:0]     start_q, stop_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               repeat_q;
  logic               clken_q, clken_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               wrap_q, wrap_d;
  logic               shadow_ld_s;
  logic               pipe_clr_s;
  logic [APR-1:0]     nxt_s;
  logic               carry_s;
  logic               step_end_s;
  logic               terminal_s;
  logic               run_dly_s;

  // Next phase value with carry out, and the end-of-sweep test on the current value.
  always_comb begin
    {carry_s, nxt_s} = {1'b0, phi_q} + {1'b0, step_q};
    step_end_s = (dwell_cnt_q == dwell_q);
    if (step_dir(64'(step_q), APR) == DIR_DOWN) begin
      // A negative step added without carry out has gone below zero.
      terminal_s = (phi_q <= stop_q) || !carry_s;
    end else begin
      terminal_s = (phi_q >= stop_q) || carry_s;
    end
  end

  // Sequencer next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    phi_d       = phi_q;
    dwell_cnt_d = dwell_cnt_q;
    drain_cnt_d = drain_cnt_q;
    shadow_ld_s = 1'b0;
    pipe_clr_s  = 1'b0;
    err_d       = 1'b0;
    wrap_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.go) begin
          if (bus.cfg_step != '0) begin
            state_d     = ST_RUN;
            phi_d       = bus.cfg_start;
            dwell_cnt_d = '0;
            shadow_ld_s = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d    = ST_IDLE;
          pipe_clr_s = 1'b1;
        end else if (step_end_s) begin
          dwell_cnt_d = '0;
          if (!terminal_s) begin
            phi_d = nxt_s;
          end else if (repeat_q) begin
            phi_d  = start_q;
            wrap_d = 1'b1;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end
      end
      ST_DRAIN: begin
        if (bus.abort) begin
          state_d    = ST_IDLE;
          pipe_clr_s = 1'b1;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    clken_d = (state_d != ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    // done is registered, so it is raised when entering the last DRAIN cycle.
    done_d  = (state_d == ST_DRAIN) && (drain_cnt_d == DRAIN_LAST);
  end

  // State, datapath, shadow configuration and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      phi_q       <= '0;
      dwell_cnt_q <= '0;
      drain_cnt_q <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      repeat_q    <= 1'b0;
      clken_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phi_q       <= phi_d;
      dwell_cnt_q <= dwell_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      clken_q     <= clken_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
      if (shadow_ld_s) begin
        start_q  <= bus.cfg_start;
        stop_q   <= bus.cfg_stop;
        step_q   <= bus.cfg_step;
        dwell_q  <= bus.cfg_dwell;
        repeat_q <= bus.cfg_repeat;
      end else begin
        start_q  <= start_q;
        stop_q   <= stop_q;
        step_q   <= step_q;
        dwell_q  <= dwell_q;
        repeat_q <= repeat_q;
      end
    end
  end

  // Tracks which NCO output samples were launched while the sweep was running.
  nco_lat_pipe #(.WIDTH(1), .DEPTH(NCO_LAT)) u_run_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .clken_i (clken_q),
    .clr_i   (pipe_clr_s),
    .d_i     (state_q == ST_RUN),
    .q_o     (run_dly_s)
  );

  assign seg_valid_o    = run_dly_s & nco_valid_i;
  assign phi_inc_o      = phi_q;
  assign nco_clken      = clken_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.sweep_wrap = wrap_q;

`ifdef NCO_SWEEP_STEP_IDX_EN
  logic [15:0] idx_q, idx_d;
  logic        idx_clr_s;
  logic        idx_inc_s;

  // Step index: restarts on an accepted go or a wrap, saturates at all-ones.
  always_comb begin
    idx_clr_s = shadow_ld_s | wrap_d;
    idx_inc_s = (state_q == ST_RUN) && !bus.abort && step_end_s && !terminal_s;
    if (idx_clr_s) begin
      idx_d = '0;
    end else if (idx_inc_s && (idx_q != 16'hFFFF)) begin
      idx_d = idx_q + 16'd1;
    end else begin
      idx_d = idx_q;
    end
  end

  // Step index register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  nco_lat_pipe #(.WIDTH(16), .DEPTH(NCO_LAT)) u_idx_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .clken_i (clken_q),
    .clr_i   (pipe_clr_s),
    .d_i     (idx_q),
    .q_o     (step_idx)
  );
`endif

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: hand sequences for reset, reject,
// abort and repeat; a table of sweeps with known step counts; randomized
// sweeps checked cycle by cycle against a reference built from the sweep rules.
module tb_nco_sweep_ctrl;

  localparam int L = 6;

  logic        clk;
  logic        reset_n;
  logic        nco_valid_i;
  logic [31:0] phi_inc_o;
  logic        nco_clken;
  logic        seg_valid_o;
`ifdef NCO_SWEEP_STEP_IDX_EN
  logic [15:0] step_idx;
`endif

  nco_sweep_ctrl_if #(.APR(32), .DWELL_W(16)) sif ();

  nco_sweep_ctrl #(.APR(32), .DWELL_W(16), .NCO_LAT(L)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (sif),
    .nco_valid_i (nco_valid_i),
    .phi_inc_o   (phi_inc_o),
    .nco_clken   (nco_clken),
    .seg_valid_o (seg_valid_o)
`ifdef NCO_SWEEP_STEP_IDX_EN
    ,
    .step_idx    (step_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  longint unsigned exp_q[$];

  typedef struct {
    logic [31:0] start;
    logic [31:0] stop;
    logic [31:0] step;
    logic [15:0] dwell;
    int          exp_n;
    logic [31:0] exp_last;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: list of phase values visited by a one-shot sweep, using true
  // integer arithmetic (a step that would leave 0..2^32-1 ends the sweep).
  function automatic void build_steps(input logic [31:0] st, input logic [31:0] sp,
                                      input logic [31:0] stp);
    longint unsigned v, mag, lim;
    bit down;
    down = stp[31];
    v    = {32'd0, st};
    lim  = {32'd0, sp};
    if (down) mag = 64'h1_0000_0000 - {32'd0, stp};
    else      mag = {32'd0, stp};
    exp_q.delete();
    for (int k = 0; k < 4096; k++) begin
      exp_q.push_back(v);
      if (!down) begin
        if (v >= lim || v + mag > 64'hFFFF_FFFF) break;
        v = v + mag;
      end else begin
        if (v <= lim || v < mag) break;
        v = v - mag;
      end
    end
  endfunction

  // Runs one one-shot sweep and checks every cycle against the reference.
  task automatic run_sweep(input logic [31:0] st, input logic [31:0] sp, input logic [31:0] stp,
                           input logic [15:0] dw, input bit noisy,
                           output int n_meas, output logic [31:0] last_meas);
    int n, per, total, busy_cnt, idx;
    bit vld, in_busy;
    build_steps(st, sp, stp);
    n     = exp_q.size();
    per   = int'(dw) + 1;
    total = n * per;
    sif.cfg_start  = st;
    sif.cfg_stop   = sp;
    sif.cfg_step   = stp;
    sif.cfg_dwell  = dw;
    sif.cfg_repeat = 1'b0;
    sif.go         = 1'b1;
    next_cycle();
    busy_cnt  = 0;
    last_meas = '0;
    for (int c = 1; c <= total + L + 1; c++) begin
      vld = 1'($urandom_range(0, 1));
      nco_valid_i = vld;
      if (noisy && c <= total + L) begin
        sif.cfg_start  = $urandom;
        sif.cfg_stop   = $urandom;
        sif.cfg_step   = 32'($urandom_range(0, 3));
        sif.cfg_dwell  = 16'($urandom_range(0, 3));
        sif.cfg_repeat = 1'($urandom_range(0, 1));
        sif.go         = 1'($urandom_range(0, 1));
      end else begin
        sif.go = 1'b0;
      end
      @(negedge clk);
      idx     = (c <= total) ? (c - 1) / per : n - 1;
      in_busy = (c <= total + L);
      check("phi", phi_inc_o, 32'(exp_q[idx]));
      check("busy", sif.busy, in_busy);
      check("clken", nco_clken, in_busy);
      check("done", sif.done, c == total + L);
      check("seg_valid", seg_valid_o, vld && (c >= L + 1) && (c <= total + L));
      check("err", sif.err, 1'b0);
      check("wrap", sif.sweep_wrap, 1'b0);
      if (sif.busy) busy_cnt++;
      if (c == total + L + 1) last_meas = phi_inc_o;
      next_cycle();
    end
    sif.go = 1'b0;
    n_meas = (busy_cnt - L) / per;
  endtask

  vec_t        vecs[6];
  int          n_meas;
  logic [31:0] last_meas;
  logic [31:0] st, sp, stp, mag;
  logic [15:0] dw;
  int          mode;
  logic [31:0] rep_vals[3];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    nco_valid_i    = 1'b1;
    sif.cfg_start  = '0;
    sif.cfg_stop   = '0;
    sif.cfg_step   = '0;
    sif.cfg_dwell  = '0;
    sif.cfg_repeat = 1'b0;
    sif.go         = 1'b0;
    sif.abort      = 1'b0;

    vecs[0] = '{32'd1000, 32'd1300, 32'd100, 16'd1, 4, 32'd1300};
    vecs[1] = '{32'd500, 32'd0, 32'hFFFF_FF38, 16'd0, 3, 32'd100};
    vecs[2] = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd0, 2, 32'hFFFF_FF80};
    vecs[3] = '{32'd0, 32'd250, 32'd100, 16'd2, 4, 32'd300};
    vecs[4] = '{32'd500, 32'd100, 32'd10, 16'd3, 1, 32'd500};
    vecs[5] = '{32'd1000, 32'd700, 32'hFFFF_FF9C, 16'd0, 4, 32'd700};

    // Reset values.
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_phi", phi_inc_o, 32'd0);
    check("rst_clken", nco_clken, 1'b0);
    check("rst_busy", sif.busy, 1'b0);
    check("rst_done", sif.done, 1'b0);
    check("rst_err", sif.err, 1'b0);
    check("rst_wrap", sif.sweep_wrap, 1'b0);
    check("rst_seg", seg_valid_o, 1'b0);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // go with a zero step is rejected.
    sif.cfg_start = 32'd77;
    sif.cfg_step  = 32'd0;
    sif.go        = 1'b1;
    next_cycle();
    sif.go = 1'b0;
    @(negedge clk);
    check("rej_err", sif.err, 1'b1);
    check("rej_busy", sif.busy, 1'b0);
    check("rej_phi", phi_inc_o, 32'd0);
    next_cycle();
    @(negedge clk);
    check("rej_err_pulse", sif.err, 1'b0);

    // abort together with go: abort wins.
    next_cycle();
    sif.cfg_step = 32'd5;
    sif.go       = 1'b1;
    sif.abort    = 1'b1;
    next_cycle();
    sif.go    = 1'b0;
    sif.abort = 1'b0;
    @(negedge clk);
    check("ab_go_busy", sif.busy, 1'b0);
    check("ab_go_err", sif.err, 1'b0);

    // abort in cycle 3 of a sweep.
    next_cycle();
    sif.cfg_start = 32'd1000;
    sif.cfg_stop  = 32'd1300;
    sif.cfg_step  = 32'd100;
    sif.cfg_dwell = 16'd1;
    sif.go        = 1'b1;
    next_cycle();
    sif.go = 1'b0;
    next_cycle();
    next_cycle();
    sif.abort = 1'b1;
    @(negedge clk);
    check("abort_c3_busy", sif.busy, 1'b1);
    check("abort_c3_phi", phi_inc_o, 32'd1100);
    next_cycle();
    sif.abort = 1'b0;
    @(negedge clk);
    check("abort_busy", sif.busy, 1'b0);
    check("abort_clken", nco_clken, 1'b0);
    check("abort_phi_hold", phi_inc_o, 32'd1100);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("abort_done", sif.done, 1'b0);
      check("abort_seg", seg_valid_o, 1'b0);
      next_cycle();
    end

    // Repeat mode: 10,15,20,10,... with a wrap pulse at each reload.
    rep_vals[0] = 32'd10;
    rep_vals[1] = 32'd15;
    rep_vals[2] = 32'd20;
    sif.cfg_start  = 32'd10;
    sif.cfg_stop   = 32'd20;
    sif.cfg_step   = 32'd5;
    sif.cfg_dwell  = 16'd0;
    sif.cfg_repeat = 1'b1;
    sif.go         = 1'b1;
    next_cycle();
    sif.go = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("rep_phi", phi_inc_o, rep_vals[(c - 1) % 3]);
      check("rep_wrap", sif.sweep_wrap, (c > 1) && ((c - 1) % 3 == 0));
      check("rep_done", sif.done, 1'b0);
      check("rep_busy", sif.busy, 1'b1);
      next_cycle();
    end
    sif.abort = 1'b1;
    next_cycle();
    sif.abort      = 1'b0;
    sif.cfg_repeat = 1'b0;
    @(negedge clk);
    check("rep_abort_busy", sif.busy, 1'b0);
    next_cycle();

    // Reset asserted mid-RUN.
    sif.cfg_start = 32'd1000;
    sif.cfg_stop  = 32'd1300;
    sif.cfg_step  = 32'd100;
    sif.cfg_dwell = 16'd1;
    sif.go        = 1'b1;
    next_cycle();
    sif.go = 1'b0;
    next_cycle();
    next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    check("mrst_phi", phi_inc_o, 32'd0);
    check("mrst_clken", nco_clken, 1'b0);
    check("mrst_busy", sif.busy, 1'b0);
    check("mrst_done", sif.done, 1'b0);
    check("mrst_seg", seg_valid_o, 1'b0);
    next_cycle();

    // Table of one-shot sweeps with known step counts and final values.
    for (int v = 0; v < 6; v++) begin
      run_sweep(vecs[v].start, vecs[v].stop, vecs[v].step, vecs[v].dwell, 1'b0, n_meas, last_meas);
      check($sformatf("tbl%0d_steps", v), 32'(n_meas), 32'(vecs[v].exp_n));
      check($sformatf("tbl%0d_last", v), last_meas, vecs[v].exp_last);
    end

    // Randomized sweeps with config noise and go pulses while busy.
    for (int r = 0; r < 25; r++) begin
      mode = int'($urandom_range(0, 2));
      mag  = 32'($urandom_range(50, 1000));
      case (mode)
        0: begin
          st  = 32'($urandom_range(0, 5000));
          sp  = 32'($urandom_range(0, 5000));
          stp = ($urandom_range(0, 1) == 1) ? (~mag + 32'd1) : mag;
        end
        1: begin
          st  = 32'hFFFF_FFFF - 32'($urandom_range(0, 3000));
          sp  = 32'hFFFF_FFFF - 32'($urandom_range(0, 500));
          stp = mag;
        end
        default: begin
          st  = 32'($urandom_range(0, 3000));
          sp  = 32'd0;
          stp = ~mag + 32'd1;
        end
      endcase
      dw = 16'($urandom_range(0, 3));
      run_sweep(st, sp, stp, dw, 1'b1, n_meas, last_meas);
      check("rnd_steps", 32'(n_meas), 32'(exp_q.size()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
